div: RTL and testbench

DIV -- requirements
Module: div

---
 rtl/div_if.sv | 19 +
 rtl/div.sv | 106 ++++++++++
 tb/tb_div.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Operand/result bundle for the restoring divider: the requester drives operands
// and start, and the divider returns the registered result and status flags.
`timescale 1ns/1ps
interface div_if #(
  parameter int wA = 16,
  parameter int wB = 16
);
  logic [wA-1:0] A;
  logic [wB-1:0] B;
  logic          start;
  logic [wA-1:0] Q;
  logic [wB-1:0] R;
  logic          fin;
  logic          busy;
  logic          dz;

  modport master (output A, B, start, input Q, R, fin, busy, dz);
  modport slave  (input A, B, start, output Q, R, fin, busy, dz);
endinterface

// File: rtl/div.sv
// Unsigned restoring divider producing one quotient bit per clock, MSB first.
// A start edge always wins: it reloads the operands and discards any division in progress.
`timescale 1ns/1ps
module div #(
  parameter int wA = 16,
  parameter int wB = 16,
  parameter int wS = 5
) (
  input  logic ck,
  input  logic rst_n,
  div_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [wA-1:0] dvd_q, dvd_d;
  logic [wB-1:0] dvs_q, dvs_d;
  logic [wB-1:0] part_q, part_d;
  logic [wS-1:0] cnt_q, cnt_d;
  logic [wA-1:0] q_q, q_d;
  logic [wB-1:0] r_q, r_d;
  logic          fin_q, fin_d;
  logic          dz_q, dz_d;

  logic [wB:0]   trial;
  logic [wB-1:0] diff;
  logic          q_bit;

  // The dividend register doubles as the quotient register: each quotient bit
  // enters at the LSB as the dividend shifts out at the MSB.
  always_comb begin
    trial = {part_q, dvd_q[wA-1]};
    q_bit = (trial >= {1'b0, dvs_q});
    diff  = trial[wB-1:0] - dvs_q;

    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    part_d  = part_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    fin_d   = 1'b0;
    dz_d    = dz_q;

    if (bus.start) begin
      state_d = RUN;
      dvd_d   = bus.A;
      dvs_d   = bus.B;
      part_d  = '0;
      cnt_d   = wS'(wA - 1);
    end else if (state_q == RUN) begin
      if (dvs_q == '0) begin
        q_d     = '1;
        r_d     = wB'(dvd_q);
        dz_d    = 1'b1;
        fin_d   = 1'b1;
        state_d = IDLE;
      end else begin
        part_d = q_bit ? diff : trial[wB-1:0];
        dvd_d  = {dvd_q[wA-2:0], q_bit};
        if (cnt_q == '0) begin
          q_d     = dvd_d;
          r_d     = part_d;
          fin_d   = 1'b1;
          dz_d    = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      part_q  <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      fin_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      part_q  <= part_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      fin_q   <= fin_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.R    = r_q;
  assign bus.fin  = fin_q;
  assign bus.dz   = dz_q;
  assign bus.busy = (state_q == RUN);

endmodule

// File: tb/tb_div.sv
// Directed and random-operand checks for the 16-bit restoring divider.
`timescale 1ns/1ps
module tb_div;

  logic ck;
  logic rst_n;

  div_if #(.wA(16), .wB(16)) bus_if ();

  div #(.wA(16), .wB(16), .wS(5)) dut (
    .ck    (ck),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  int assert_count = 0;
  int fail_count   = 0;

  int          res_cycles;
  int          res_busy;
  logic [15:0] mid_q;
  logic        mid_dz;
  int          fin_seen;

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change only just after a falling edge; ends at the falling edge after the start edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    bus_if.A     = a;
    bus_if.B     = b;
    bus_if.start = 1'b1;
    @(negedge ck);
    bus_if.start = 1'b0;
  endtask

  task automatic runDiv(input logic [15:0] a, input logic [15:0] b);
    applyStimulus(a, b);
    res_cycles = 0;
    res_busy   = 0;
    mid_q      = 'x;
    mid_dz     = 1'bx;
    while (!bus_if.fin && res_cycles < 40) begin
      if (bus_if.busy) res_busy++;
      if (res_cycles == 8) begin
        mid_q  = bus_if.Q;
        mid_dz = bus_if.dz;
      end
      @(negedge ck);
      res_cycles++;
    end
  endtask

  task automatic countFin(input int cycles);
    fin_seen = 0;
    repeat (cycles) begin
      @(negedge ck);
      if (bus_if.fin) fin_seen++;
    end
  endtask

  initial begin
    logic [15:0] ra, rb;

    rst_n        = 1'b1;
    bus_if.A     = '0;
    bus_if.B     = '0;
    bus_if.start = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    checkOutput("reset_q",    bus_if.Q,    16'h0);
    checkOutput("reset_r",    bus_if.R,    16'h0);
    checkOutput("reset_fin",  bus_if.fin,  1'b0);
    checkOutput("reset_busy", bus_if.busy, 1'b0);
    checkOutput("reset_dz",   bus_if.dz,   1'b0);
    repeat (2) @(negedge ck);
    rst_n = 1'b1;
    @(negedge ck);

    $display("[TB] basic 100/7");
    runDiv(16'd100, 16'd7);
    checkOutput("basic_latency", res_cycles, 16);
    checkOutput("basic_busy_cycles", res_busy, 16);
    checkOutput("basic_q",  bus_if.Q,  16'd14);
    checkOutput("basic_r",  bus_if.R,  16'd2);
    checkOutput("basic_dz", bus_if.dz, 1'b0);
    checkOutput("basic_busy_at_fin", bus_if.busy, 1'b0);
    @(negedge ck);
    checkOutput("basic_fin_drop", bus_if.fin, 1'b0);
    checkOutput("basic_q_hold", bus_if.Q, 16'd14);

    $display("[TB] extreme operands");
    runDiv(16'hFFFF, 16'h0001);
    checkOutput("max_by_one_q", bus_if.Q, 16'hFFFF);
    checkOutput("max_by_one_r", bus_if.R, 16'h0000);
    runDiv(16'hFFFF, 16'hFFFF);
    checkOutput("max_by_max_q", bus_if.Q, 16'h0001);
    checkOutput("max_by_max_r", bus_if.R, 16'h0000);
    checkOutput("max_by_max_mid_q", mid_q, 16'hFFFF);

    $display("[TB] dividend below divisor");
    runDiv(16'd5, 16'd9);
    checkOutput("small_latency", res_cycles, 16);
    checkOutput("small_q", bus_if.Q, 16'd0);
    checkOutput("small_r", bus_if.R, 16'd5);

    $display("[TB] divide by zero");
    runDiv(16'h1234, 16'h0000);
    checkOutput("dz_latency", res_cycles, 1);
    checkOutput("dz_q",    bus_if.Q,    16'hFFFF);
    checkOutput("dz_r",    bus_if.R,    16'h1234);
    checkOutput("dz_flag", bus_if.dz,   1'b1);
    checkOutput("dz_busy", bus_if.busy, 1'b0);
    @(negedge ck);
    checkOutput("dz_fin_drop", bus_if.fin, 1'b0);
    runDiv(16'd10, 16'd3);
    checkOutput("dz_hold_mid", mid_dz, 1'b1);
    checkOutput("dz_q_hold_mid", mid_q, 16'hFFFF);
    checkOutput("dz_clear_latency", res_cycles, 16);
    checkOutput("dz_clear_flag", bus_if.dz, 1'b0);
    checkOutput("dz_clear_q", bus_if.Q, 16'd3);
    checkOutput("dz_clear_r", bus_if.R, 16'd1);

    $display("[TB] restart mid-run");
    applyStimulus(16'd1000, 16'd10);
    countFin(4);
    checkOutput("restart_no_early_fin", fin_seen, 0);
    runDiv(16'd50, 16'd6);
    checkOutput("restart_latency", res_cycles, 16);
    checkOutput("restart_q", bus_if.Q, 16'd8);
    checkOutput("restart_r", bus_if.R, 16'd2);
    countFin(20);
    checkOutput("restart_single_fin", fin_seen, 0);

    $display("[TB] reset mid-run");
    applyStimulus(16'd1000, 16'd7);
    repeat (7) @(negedge ck);
    checkOutput("rst_busy_before", bus_if.busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_q",    bus_if.Q,    16'h0);
    checkOutput("rst_async_r",    bus_if.R,    16'h0);
    checkOutput("rst_async_busy", bus_if.busy, 1'b0);
    checkOutput("rst_async_fin",  bus_if.fin,  1'b0);
    checkOutput("rst_async_dz",   bus_if.dz,   1'b0);
    bus_if.A     = 16'd77;
    bus_if.B     = 16'd5;
    bus_if.start = 1'b1;
    @(negedge ck);
    checkOutput("rst_start_ignored", bus_if.busy, 1'b0);
    bus_if.start = 1'b0;
    rst_n        = 1'b1;
    countFin(25);
    checkOutput("rst_no_fin", fin_seen, 0);
    runDiv(16'd9, 16'd4);
    checkOutput("rst_next_latency", res_cycles, 16);
    checkOutput("rst_next_q", bus_if.Q, 16'd2);
    checkOutput("rst_next_r", bus_if.R, 16'd1);

    $display("[TB] start held high");
    bus_if.A     = 16'd200;
    bus_if.B     = 16'd3;
    bus_if.start = 1'b1;
    @(negedge ck);
    @(negedge ck);
    runDiv(16'd200, 16'd9);
    checkOutput("held_latency", res_cycles, 16);
    checkOutput("held_q", bus_if.Q, 16'd22);
    checkOutput("held_r", bus_if.R, 16'd2);

    $display("[TB] random operands");
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = (i % 4 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
      runDiv(ra, rb);
      checkOutput("rand_latency", res_cycles, 16);
      checkOutput("rand_identity", 64'(bus_if.Q) * 64'(rb) + 64'(bus_if.R), 64'(ra));
      checkOutput("rand_r_lt_b", (bus_if.R < rb), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
